// File: rtl/block_config_latch_mem.sv
// block_config_latch_mem
// Truth-table storage for one LUT. The whole table is loaded in one parallel
// write on the configuration clock. A binary mux tree, steered by the LUT
// input address, drives the selected table bit out combinationally.
module block_config_latch_mem #(
    parameter  int ADDR_BITS = 4,
    localparam int MEM_SIZE  = 2 ** ADDR_BITS
) (
    input  logic                 cclk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic [MEM_SIZE-1:0]  config_in,
    input  logic [ADDR_BITS-1:0] addr,
    output logic                 out
);

    // Stored truth table; bit i is the LUT output for addr == i.
    logic [MEM_SIZE-1:0] mem;

    // Heap-ordered mux tree. Node n has children 2n and 2n+1.
    // Root is node 1, and the leaves are nodes MEM_SIZE .. 2*MEM_SIZE-1.
    // Leaf MEM_SIZE+i holds mem[i], so walking down from the root with addr
    // MSB first ends on mem[addr], and addr[0] picks at the leaf level.
    logic [2*MEM_SIZE-1:1] tree;

    // Whole-table load on an enabled configuration edge.
    // Reset clears the table at once, without waiting for a clock edge.
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (cen) begin
            mem <= config_in;
        end
    end

    assign tree[2*MEM_SIZE-1:MEM_SIZE] = mem;

    // Each node at depth d selects between its two children using addr bit
    // (ADDR_BITS-1-d), so the deepest mux level is steered by addr[0].
    for (genvar d = 0; d < ADDR_BITS; d++) begin : g_level
        for (genvar i = 0; i < (1 << d); i++) begin : g_node
            localparam int N = (1 << d) + i;
            assign tree[N] = addr[ADDR_BITS-1-d] ? tree[2*N+1] : tree[2*N];
        end
    end

    assign out = tree[1];

endmodule

// File: tb/tb_block_config_latch_mem.sv
// Bench for block_config_latch_mem.
// Three instances are driven from shared cclk/rst/cen: ADDR_BITS = 4, 1 and 6.
// A reference table is kept per instance. Expected read values are queued
// when an address is driven, then popped and compared once out has settled.
module tb_block_config_latch_mem;

    logic        cclk = 1'b0;
    logic        rst  = 1'b1;
    logic        cen  = 1'b0;

    logic [15:0] config4 = '0;
    logic [1:0]  config1 = '0;
    logic [63:0] config6 = '0;
    logic [3:0]  addr4   = '0;
    logic [0:0]  addr1   = '0;
    logic [5:0]  addr6   = '0;
    logic        out4;
    logic        out1;
    logic        out6;

    logic [15:0] model4 = '0;
    logic [1:0]  model1 = '0;
    logic [63:0] model6 = '0;

    typedef struct {
        int   which;
        int   a;
        logic exp;
    } sb_entry_t;

    sb_entry_t sb[$];

    int checks   = 0;
    int failures = 0;

    block_config_latch_mem #(.ADDR_BITS(4)) dut4 (
        .cclk(cclk), .rst(rst), .cen(cen),
        .config_in(config4), .addr(addr4), .out(out4)
    );

    block_config_latch_mem #(.ADDR_BITS(1)) dut1 (
        .cclk(cclk), .rst(rst), .cen(cen),
        .config_in(config1), .addr(addr1), .out(out1)
    );

    block_config_latch_mem #(.ADDR_BITS(6)) dut6 (
        .cclk(cclk), .rst(rst), .cen(cen),
        .config_in(config6), .addr(addr6), .out(out6)
    );

    // Slow clock, so a full 64-address sweep fits between two edges.
    always #100 cclk = ~cclk;

    // Drive one address on one instance and queue the bit the table should give.
    task automatic apply_stimulus(input int which, input int a);
        sb_entry_t e;
        e.which = which;
        e.a     = a;
        case (which)
            1:       begin addr1 = a[0:0]; e.exp = model1[a[0:0]]; end
            6:       begin addr6 = a[5:0]; e.exp = model6[a[5:0]]; end
            default: begin addr4 = a[3:0]; e.exp = model4[a[3:0]]; end
        endcase
        sb.push_back(e);
    endtask

    // Let the read path settle, then pop the oldest expectation and compare it.
    task automatic check_output(input string tag);
        sb_entry_t e;
        logic      obs;
        #1;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("[TB] FAIL %s scoreboard empty observed=none expected=entry", tag);
        end else begin
            e = sb.pop_front();
            case (e.which)
                1:       obs = out1;
                6:       obs = out6;
                default: obs = out4;
            endcase
            assert (obs === e.exp) else begin
                failures++;
                $error("[TB] FAIL %s w=%0d addr=%0d observed=%b expected=%b",
                       tag, e.which, e.a, obs, e.exp);
            end
        end
    endtask

    // Read back every address of one instance.
    task automatic sweep(input int which, input string tag);
        for (int a = 0; a < (1 << which); a++) begin
            apply_stimulus(which, a);
            check_output(tag);
        end
    endtask

    // Present new tables and cen before a rising edge, then track the load.
    task automatic clock_edge(input logic en, input logic [15:0] c4,
                              input logic [1:0] c1, input logic [63:0] c6);
        @(negedge cclk);
        cen     = en;
        config4 = c4;
        config1 = c1;
        config6 = c6;
        @(posedge cclk);
        if (!rst && en) begin
            model4 = c4;
            model1 = c1;
            model6 = c6;
        end
        #1;
    endtask

    initial begin
        logic [63:0] walk;

        // Power-up reset: every table reads zero.
        #5;
        sweep(4, "reset_init4");
        sweep(1, "reset_init1");
        sweep(6, "reset_init6");
        @(negedge cclk);
        rst = 1'b0;

        // All-ones load, then an asynchronous reset between edges.
        clock_edge(1'b1, 16'hFFFF, 2'b11, {64{1'b1}});
        sweep(4, "load_ffff");
        @(negedge cclk);
        #10;
        rst    = 1'b1;
        model4 = '0;
        model1 = '0;
        model6 = '0;
        sweep(4, "async_reset");

        // Enabled edge while reset is held loads nothing.
        clock_edge(1'b1, 16'hFFFF, 2'b11, {64{1'b1}});
        sweep(4, "edge_in_reset");
        sweep(6, "edge_in_reset6");
        @(negedge cclk);
        rst = 1'b0;

        // Block load of a mixed pattern.
        clock_edge(1'b1, 16'hA5C3, 2'b01, 64'h0123_4567_89AB_CDEF);
        sweep(4, "load_a5c3");
        sweep(6, "load_mixed6");

        // Disabled edges keep the table despite a changed config_in.
        for (int k = 0; k < 5; k++) begin
            clock_edge(1'b0, 16'h0000, 2'b00, 64'h0);
        end
        sweep(4, "hold_cen0");

        // Back-to-back reloads, the last edge wins.
        clock_edge(1'b1, 16'h8000, 2'b01, 64'h0);
        sweep(4, "reload_8000");
        clock_edge(1'b1, 16'h0001, 2'b10, 64'h0);
        sweep(4, "reload_0001");

        // Single-input table: addr0 reads 0, addr1 reads 1.
        sweep(1, "abits1");

        // Six-input table: walking one, seen only at its own address.
        for (int p = 0; p < 64; p++) begin
            walk = 64'h1 << p;
            clock_edge(1'b1, 16'h0000, 2'b00, walk);
            sweep(6, "walk6");
        end

        cen = 1'b0;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL sb_drain observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
